// File: rtl/yga1_cal_pkg.sv
// yga1_cal_pkg: shared sizes, default Y/W ROM tables and the shift-and-saturate helper
package yga1_cal_pkg;
    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int FRAC = 12;
    localparam int ACCW = 36;
    localparam int PW   = 33;
    localparam int IW   = $clog2(N);

    typedef logic [N-1:0][DW-1:0] tab_t;

    // Element [k] of each table is entry k; Y_r[k] = 0x0200*(k+1)
    localparam tab_t Y_R_DEF = {16'h1000, 16'h0E00, 16'h0C00, 16'h0A00,
                                16'h0800, 16'h0600, 16'h0400, 16'h0200};
    localparam tab_t Y_I_DEF = {N{16'h0100}};
    localparam tab_t W_R_DEF = {N{16'h0800}};
    localparam tab_t W_I_DEF = {N{16'h0400}};

    localparam logic signed [ACCW-1:0] SMAX = 2 ** (DW - 1) - 1;
    localparam logic signed [ACCW-1:0] SMIN = -(2 ** (DW - 1));

    // Arithmetic shift (floor) back to Q4.12, then clamp to the signed DW range
    function automatic logic [DW-1:0] sat_shift(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> FRAC;
        return s > SMAX ? DW'(SMAX) : s < SMIN ? DW'(SMIN) : s[DW-1:0];
    endfunction
endpackage

// File: rtl/yga1_cal_cmul.sv
// yga1_cal_cmul: registered non-conjugated 16x16 complex multiplier, one cycle latency
// Ports: clk, rst (async active-low), ar/ai x br/bi operands, pr/pi 33-bit products
module yga1_cal_cmul
    import yga1_cal_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ar,
    input  logic [DW-1:0] ai,
    input  logic [DW-1:0] br,
    input  logic [DW-1:0] bi,
    output logic [PW-1:0] pr,
    output logic [PW-1:0] pi
);
    logic signed [31:0] rr, ii, ri, ir;

    assign rr = $signed(ar) * $signed(br);
    assign ii = $signed(ai) * $signed(bi);
    assign ri = $signed(ar) * $signed(bi);
    assign ir = $signed(ai) * $signed(br);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pr <= '0;
            pi <= '0;
        end else begin
            pr <= PW'(rr) - PW'(ii);
            pi <= PW'(ri) + PW'(ir);
        end
    end
endmodule

// File: rtl/yga1_cal.sv
// yga1_cal: self-running complex MAC over constant Y and W tables, one saturated result per frame
// Ports: clk, rst (async active-low), out_r/out_i Q4.12 frame result
module yga1_cal
    import yga1_cal_pkg::*;
#(
    parameter tab_t Y_R = Y_R_DEF,
    parameter tab_t Y_I = Y_I_DEF,
    parameter tab_t W_R = W_R_DEF,
    parameter tab_t W_I = W_I_DEF
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i
);
    logic [IW-1:0] idx;
    logic first_q, last_q, valid;
    logic signed [PW-1:0] pr, pi;
    logic signed [ACCW-1:0] acc_r, acc_i, sum_r, sum_i;

    yga1_cal_cmul u_cmul (
        .clk(clk),
        .rst(rst),
        .ar (Y_R[idx]),
        .ai (Y_I[idx]),
        .br (W_R[idx]),
        .bi (W_I[idx]),
        .pr (pr),
        .pi (pi)
    );

    // The first product of a frame replaces the running sum, so frames never leak into each other
    assign sum_r = first_q ? ACCW'(pr) : acc_r + ACCW'(pr);
    assign sum_i = first_q ? ACCW'(pi) : acc_i + ACCW'(pi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid   <= 1'b0;
            acc_r   <= '0;
            acc_i   <= '0;
            out_r   <= '0;
            out_i   <= '0;
        end else begin
            idx     <= idx + 1'b1;
            first_q <= idx == '0;
            last_q  <= idx == IW'(N - 1);
            valid   <= 1'b1;
            if (valid) begin
                acc_r <= sum_r;
                acc_i <= sum_i;
            end
            if (valid && last_q) begin
                out_r <= sat_shift(sum_r);
                out_i <= sat_shift(sum_i);
            end
        end
    end
endmodule

// File: tb/tb_yga1_cal.sv
module tb_yga1_cal;
    import yga1_cal_pkg::*;

    localparam tab_t Z     = '0;
    localparam tab_t PMAX  = {N{16'h7FFF}};
    localparam tab_t NMAX  = {N{16'h8000}};
    localparam tab_t ONE_M = tab_t'(16'hFFFF);
    localparam tab_t ONE_P = tab_t'(16'h0001);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [DW-1:0] d_r, d_i, p_r, p_i, n_r, n_i, s_r, s_i;
    logic [DW-1:0] e_d_r, e_d_i, e_p_r, e_p_i, e_n_r, e_n_i, e_s_r, e_s_i;
    int vectors = 0;
    int miscompares = 0;
    int ed = 0;

    always #5 clk = ~clk;

    yga1_cal u_def (.clk(clk), .rst(rst), .out_r(d_r), .out_i(d_i));
    yga1_cal #(.Y_R(PMAX), .Y_I(Z), .W_R(PMAX), .W_I(Z))
        u_sp (.clk(clk), .rst(rst), .out_r(p_r), .out_i(p_i));
    yga1_cal #(.Y_R(NMAX), .Y_I(Z), .W_R(PMAX), .W_I(Z))
        u_sn (.clk(clk), .rst(rst), .out_r(n_r), .out_i(n_i));
    yga1_cal #(.Y_R(ONE_M), .Y_I(Z), .W_R(ONE_P), .W_I(Z))
        u_sg (.clk(clk), .rst(rst), .out_r(s_r), .out_i(s_i));

    function automatic logic [15:0] clamp(input longint v);
        longint s;
        s = v >>> FRAC;
        return s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : 16'(s);
    endfunction

    // Reference: plain integer sum of complex products over one frame
    task automatic frame(input tab_t yr, input tab_t yi, input tab_t wr, input tab_t wi,
                         output logic [15:0] er, output logic [15:0] ei);
        longint sr, si, a, b, c, d;
        sr = 0;
        si = 0;
        for (int k = 0; k < N; k++) begin
            a = longint'($signed(yr[k]));
            b = longint'($signed(yi[k]));
            c = longint'($signed(wr[k]));
            d = longint'($signed(wi[k]));
            sr += a * c - b * d;
            si += a * d + b * c;
        end
        er = clamp(sr);
        ei = clamp(si);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s ed=%0d observed=%h expected=%h", tag, ed, obs, exp);
        end
    endtask

    // Outputs are zero until edge N+1 after release, then hold the constant frame result
    task automatic chk_all();
        bit up;
        up = ed >= N + 1;
        chk("def_r", d_r, up ? e_d_r : 16'h0);
        chk("def_i", d_i, up ? e_d_i : 16'h0);
        chk("satp_r", p_r, up ? e_p_r : 16'h0);
        chk("satp_i", p_i, up ? e_p_i : 16'h0);
        chk("satn_r", n_r, up ? e_n_r : 16'h0);
        chk("satn_i", n_i, up ? e_n_i : 16'h0);
        chk("sign_r", s_r, up ? e_s_r : 16'h0);
        chk("sign_i", s_i, up ? e_s_i : 16'h0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) ed++;
        #1;
        chk_all();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        ed = 0;
        chk_all();
    endtask

    initial begin
        frame(Y_R_DEF, Y_I_DEF, W_R_DEF, W_I_DEF, e_d_r, e_d_i);
        frame(PMAX, Z, PMAX, Z, e_p_r, e_p_i);
        frame(NMAX, Z, PMAX, Z, e_n_r, e_n_i);
        frame(ONE_M, Z, ONE_P, Z, e_s_r, e_s_i);
        chk("exp_def_r", e_d_r, 16'h2200);
        chk("exp_def_i", e_d_i, 16'h1600);
        chk("exp_sign_r", e_s_r, 16'hFFFF);
        repeat (2) step();
        @(negedge clk) rst = 1'b1;
        repeat (200) step();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        ed = 0;
        while (ed < 12) step();
        async_reset();
        repeat (3) step();
        @(negedge clk) rst = 1'b1;
        repeat (40) step();
        repeat (6) begin
            repeat ($urandom_range(1, 30)) step();
            #($urandom_range(1, 3));
            async_reset();
            repeat ($urandom_range(1, 4)) step();
            @(negedge clk) rst = 1'b1;
        end
        repeat (20) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
